// File: rtl/cae_sort_sequencer.sv
// Block sorter: loads N words, sorts them in place with a single registered
// compare-exchange stage (odd-even transposition), then streams them out.
module cae_sort_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int N          = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  dir,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  busy,
    output logic                  sort_done
);
    localparam int IDX_W = $clog2(N);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CMP, S_WB, S_OUT} state_t;

    state_t                  state_q;
    logic [DATA_WIDTH-1:0]   mem [N];
    logic [IDX_W-1:0]        wr_idx_q, rd_idx_q, j_q, phase_q;
    logic                    dir_q;
    logic [DATA_WIDTH-1:0]   lo_q, hi_q, out_data_q;
    logic                    in_ready_q, out_valid_q, out_last_q, busy_q, sort_done_q;

    logic [IDX_W-1:0]        j_hi_d, rd_next_d, load_addr_d;
    logic [DATA_WIDTH-1:0]   a_d, b_d, lo_d, hi_d;
    logic                    load_we_d, wb_we_d, last_pair_d;
    logic [N-1:0]            sel_ld_d, sel_lo_d, sel_hi_d;

    assign j_hi_d      = j_q + IDX_W'(1);
    assign rd_next_d   = rd_idx_q + IDX_W'(1);
    assign a_d         = mem[j_q];
    assign b_d         = mem[j_hi_d];
    // Equal operands take either branch; both outputs are then identical.
    assign lo_d        = (dir_q == (a_d < b_d)) ? a_d : b_d;
    assign hi_d        = (dir_q == (a_d < b_d)) ? b_d : a_d;
    assign load_we_d   = in_valid && in_ready_q && (state_q == S_IDLE || state_q == S_LOAD);
    assign load_addr_d = (state_q == S_IDLE) ? '0 : wr_idx_q;
    assign wb_we_d     = (state_q == S_WB);
    assign last_pair_d = phase_q[0] ? (j_q == IDX_W'(N - 3)) : (j_q == IDX_W'(N - 2));

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_wsel
            assign sel_ld_d[gi] = load_we_d && (load_addr_d == IDX_W'(gi));
            assign sel_lo_d[gi] = wb_we_d && (j_q == IDX_W'(gi));
            assign sel_hi_d[gi] = wb_we_d && (j_hi_d == IDX_W'(gi));
        end
    endgenerate

    // Buffer has no reset; its contents are meaningless until loaded.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < N; k++) begin
                if (sel_ld_d[k])      mem[k] <= in_data;
                else if (sel_lo_d[k]) mem[k] <= lo_q;
                else if (sel_hi_d[k]) mem[k] <= hi_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wr_idx_q    <= '0;
            rd_idx_q    <= '0;
            j_q         <= '0;
            phase_q     <= '0;
            dir_q       <= 1'b0;
            lo_q        <= '0;
            hi_q        <= '0;
            out_data_q  <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            sort_done_q <= 1'b0;
        end else begin
            sort_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        dir_q    <= dir;
                        wr_idx_q <= IDX_W'(1);
                        busy_q   <= 1'b1;
                        state_q  <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (in_valid) begin
                        if (wr_idx_q == IDX_W'(N - 1)) begin
                            wr_idx_q   <= '0;
                            in_ready_q <= 1'b0;
                            phase_q    <= '0;
                            j_q        <= '0;
                            state_q    <= S_CMP;
                        end else begin
                            wr_idx_q <= wr_idx_q + IDX_W'(1);
                        end
                    end
                end
                S_CMP: begin
                    lo_q    <= lo_d;
                    hi_q    <= hi_d;
                    state_q <= S_WB;
                end
                S_WB: begin
                    if (!last_pair_d) begin
                        j_q     <= j_q + IDX_W'(2);
                        state_q <= S_CMP;
                    end else if (phase_q == IDX_W'(N - 1)) begin
                        // Final phase is odd, so mem[0] is not being rewritten here.
                        rd_idx_q    <= '0;
                        out_data_q  <= mem[0];
                        out_valid_q <= 1'b1;
                        out_last_q  <= 1'b0;
                        sort_done_q <= 1'b1;
                        state_q     <= S_OUT;
                    end else begin
                        phase_q <= phase_q + IDX_W'(1);
                        j_q     <= {{(IDX_W - 1){1'b0}}, ~phase_q[0]};
                        state_q <= S_CMP;
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        if (out_last_q) begin
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            in_ready_q  <= 1'b1;
                            busy_q      <= 1'b0;
                            rd_idx_q    <= '0;
                            state_q     <= S_IDLE;
                        end else begin
                            rd_idx_q   <= rd_next_d;
                            out_data_q <= mem[rd_next_d];
                            out_last_q <= (rd_next_d == IDX_W'(N - 1));
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign sort_done = sort_done_q;
endmodule
